// File: rtl/iq_modulator_if.sv
// Baseband I/Q sample stream into the IQ modulator: valid/ready handshake
// carrying one signed I/Q pair per transfer.
interface iq_modulator_if #(
  parameter int N = 14
);
  logic                in_valid;
  logic                in_ready;
  logic signed [N-1:0] in_I;
  logic signed [N-1:0] in_Q;

  modport master (output in_valid, output in_I, output in_Q, input  in_ready);
  modport slave  (input  in_valid, input  in_I, input  in_Q, output in_ready);
endinterface

// File: rtl/iq_modulator.sv
// Digital IQ upconverter: holds each baseband pair for H clocks, mixes it with a
// quadrature NCO (y = I*cos - Q*sin) and drives a saturated signed/offset-binary sample.
module iq_modulator #(
  parameter int N        = 14,
  parameter int PHASE_W  = 32,
  parameter int LUT_ADDR = 10
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic [PHASE_W-1:0]  phase_inc,
  input  logic [PHASE_W-1:0]  phase_offset,
  input  logic [7:0]          interp,
  iq_modulator_if.slave       s_in,
  output logic signed [N-1:0] out_signed,
  output logic [N-1:0]        out_unsigned,
  output logic                out_valid,
  output logic                sync_o,
  output logic                underflow
);
  localparam int                  DEPTH   = 1 << LUT_ADDR;
  localparam logic [LUT_ADDR-1:0] QUARTER = LUT_ADDR'(DEPTH / 4);
  localparam real                 PI      = 3.14159265358979323846;
  localparam logic signed [2*N:0] SAT_MAX = (2*N+1)'((1 << (N-1)) - 1);
  localparam logic signed [2*N:0] SAT_MIN = -SAT_MAX - (2*N+1)'(1);

  // Full-cycle sine ROM, contents fixed at elaboration.
  function automatic logic signed [N-1:0] sin_entry(input int k);
    real v;
    int  r;
    v = real'((1 << (N-1)) - 1) * $sin(2.0 * PI * real'(k) / real'(DEPTH));
    r = (v >= 0.0) ? $rtoi(v + 0.5) : -$rtoi(0.5 - v);
    return N'(r);
  endfunction

  logic signed [N-1:0] sin_lut [DEPTH];
  for (genvar k = 0; k < DEPTH; k++) begin : g_lut
    assign sin_lut[k] = sin_entry(k);
  end

  logic [7:0]          cnt;
  logic [7:0]          hold_last;
  logic                strobe;
  logic                xfer;
  logic                buf_full;
  logic signed [N-1:0] buf_I, buf_Q;
  logic signed [N-1:0] op_I, op_Q;

  assign hold_last      = (interp == 8'd0) ? 8'd0 : interp - 8'd1;
  assign strobe         = cnt >= hold_last;
  assign s_in.in_ready  = !buf_full || strobe;
  assign xfer           = s_in.in_valid && s_in.in_ready;

  always_ff @(posedge CLK) begin
    if (reset) begin
      cnt       <= '0;
      buf_full  <= 1'b0;
      buf_I     <= '0;
      buf_Q     <= '0;
      op_I      <= '0;
      op_Q      <= '0;
      underflow <= 1'b0;
    end else begin
      cnt <= strobe ? '0 : cnt + 8'd1;
      if (strobe) begin
        if (buf_full) begin
          op_I     <= buf_I;
          op_Q     <= buf_Q;
          buf_full <= xfer;
          if (xfer) begin
            buf_I <= s_in.in_I;
            buf_Q <= s_in.in_Q;
          end
        end else if (xfer) begin
          op_I <= s_in.in_I;
          op_Q <= s_in.in_Q;
        end else begin
          op_I      <= '0;
          op_Q      <= '0;
          underflow <= 1'b1;
        end
      end else if (xfer) begin
        buf_I    <= s_in.in_I;
        buf_Q    <= s_in.in_Q;
        buf_full <= 1'b1;
      end
    end
  end

  logic [PHASE_W-1:0]  acc;
  logic [PHASE_W:0]    acc_sum;
  logic                wrap_q;
  logic [PHASE_W-1:0]  ph_unused;
  logic [LUT_ADDR-1:0] ph_idx;

  // wrap_q flags the accumulator value produced by a carry, so the sync pulse
  // travels with the first post-wrap phase rather than the last pre-wrap one.
  assign acc_sum   = {1'b0, acc} + {1'b0, phase_inc};
  assign ph_unused = acc + phase_offset;
  assign ph_idx    = ph_unused[PHASE_W-1 -: LUT_ADDR];

  logic [LUT_ADDR-1:0]  sin_addr, cos_addr;
  logic signed [N-1:0]  s1_I, s1_Q, s2_I, s2_Q;
  logic signed [N-1:0]  sin_q, cos_q;
  logic signed [2*N-1:0] p_I, p_Q;
  logic                 s1_sync, s2_sync, s3_sync;
  logic [3:0]           vpipe;
  logic signed [2*N:0]  s_diff, r_sh;
  logic signed [N-1:0]  y_sat;

  always_comb begin
    s_diff = (2*N+1)'(p_I) - (2*N+1)'(p_Q);
    r_sh   = s_diff >>> (N-1);
    y_sat  = r_sh[N-1:0];
    if (r_sh > SAT_MAX)      y_sat = SAT_MAX[N-1:0];
    else if (r_sh < SAT_MIN) y_sat = SAT_MIN[N-1:0];
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      acc        <= '0;
      wrap_q     <= 1'b0;
      sin_addr   <= '0;
      cos_addr   <= '0;
      s1_I       <= '0;
      s1_Q       <= '0;
      s1_sync    <= 1'b0;
      sin_q      <= '0;
      cos_q      <= '0;
      s2_I       <= '0;
      s2_Q       <= '0;
      s2_sync    <= 1'b0;
      p_I        <= '0;
      p_Q        <= '0;
      s3_sync    <= 1'b0;
      out_signed <= '0;
      sync_o     <= 1'b0;
      vpipe      <= '0;
    end else begin
      acc        <= acc_sum[PHASE_W-1:0];
      wrap_q     <= acc_sum[PHASE_W];
      sin_addr   <= ph_idx;
      cos_addr   <= ph_idx + QUARTER;
      s1_I       <= op_I;
      s1_Q       <= op_Q;
      s1_sync    <= wrap_q;
      sin_q      <= sin_lut[sin_addr];
      cos_q      <= sin_lut[cos_addr];
      s2_I       <= s1_I;
      s2_Q       <= s1_Q;
      s2_sync    <= s1_sync;
      p_I        <= (2*N)'(s2_I) * (2*N)'(cos_q);
      p_Q        <= (2*N)'(s2_Q) * (2*N)'(sin_q);
      s3_sync    <= s2_sync;
      out_signed <= y_sat;
      sync_o     <= s3_sync;
      vpipe      <= {vpipe[2:0], 1'b1};
    end
  end

  assign out_valid    = vpipe[3];
  assign out_unsigned = {~out_signed[N-1], out_signed[N-2:0]};

endmodule
